// File: rtl/mealy_table_ctrl.sv
// mealy_table_ctrl: runs any Mealy machine of up to 2^STATE_W states from a writable transition table
module mealy_table_ctrl #(
    parameter int STATE_W    = 3,
    parameter int IN_W       = 2,
    parameter int NUM_STATES = 3,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [STATE_W-1:0] cfg_state,
    input  logic [IN_W-1:0]    cfg_sym,
    input  logic [STATE_W-1:0] cfg_next,
    input  logic               cfg_out,
    input  logic [STATE_W-1:0] init_state,
    input  logic               start,
    input  logic               stop,
    input  logic               sym_valid,
    input  logic [IN_W-1:0]    sym,
    output logic               sym_ready,
    output logic [STATE_W-1:0] state,
    output logic               out,
    output logic               out_valid,
    output logic               busy,
    output logic               fault,
    output logic [CNT_W-1:0]   step_cnt
);
    localparam int DEPTH = 1 << (STATE_W + IN_W);
    localparam logic [STATE_W:0] NUM_S = (STATE_W + 1)'(NUM_STATES);

    typedef enum logic [1:0] {IDLE, RUN, FAULT} ctrl_t;

    ctrl_t                             ctrl_q, ctrl_d;
    logic [DEPTH-1:0][STATE_W-1:0]     tbl_next_q, tbl_next_d;
    logic [DEPTH-1:0]                  tbl_out_q, tbl_out_d;
    logic [DEPTH-1:0]                  tbl_wr_q, tbl_wr_d;
    logic [STATE_W-1:0]                state_q, state_d;
    logic                              out_q, out_d;
    logic                              out_valid_q, out_valid_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [STATE_W+IN_W-1:0]           cfg_idx, step_idx;

    function automatic logic legal(input logic [STATE_W-1:0] s);
        return {1'b0, s} < NUM_S;
    endfunction

    assign cfg_idx   = {cfg_state, cfg_sym};
    assign step_idx  = {state_q, sym};
    assign sym_ready = (ctrl_q == RUN) && !stop;
    assign busy      = ctrl_q == RUN;
    assign fault     = ctrl_q == FAULT;
    assign state     = state_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign step_cnt  = cnt_q;

    always_comb begin
        ctrl_d      = ctrl_q;
        tbl_next_d  = tbl_next_q;
        tbl_out_d   = tbl_out_q;
        tbl_wr_d    = tbl_wr_q;
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        cnt_d       = cnt_q;
        if (ctrl_q == IDLE && cfg_we && legal(cfg_state) && legal(cfg_next)) begin
            tbl_next_d[cfg_idx] = cfg_next;
            tbl_out_d[cfg_idx]  = cfg_out;
            tbl_wr_d[cfg_idx]   = 1'b1;
        end
        if (ctrl_q == RUN) begin
            if (stop) begin
                ctrl_d = IDLE;
            end else if (sym_valid) begin
                // an unwritten entry means the loaded machine is incomplete
                if (tbl_wr_q[step_idx]) begin
                    state_d     = tbl_next_q[step_idx];
                    out_d       = tbl_out_q[step_idx];
                    out_valid_d = 1'b1;
                    cnt_d       = &cnt_q ? cnt_q : cnt_q + 1'b1;
                end else begin
                    ctrl_d = FAULT;
                end
            end
        end else if (start) begin
            if (legal(init_state)) begin
                ctrl_d  = RUN;
                state_d = init_state;
                out_d   = 1'b0;
                cnt_d   = '0;
            end else begin
                ctrl_d = FAULT;
            end
        end else if (stop) begin
            ctrl_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q      <= IDLE;
            tbl_next_q  <= '0;
            tbl_out_q   <= '0;
            tbl_wr_q    <= '0;
            state_q     <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            tbl_next_q  <= tbl_next_d;
            tbl_out_q   <= tbl_out_d;
            tbl_wr_q    <= tbl_wr_d;
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mealy_table_ctrl.sv
// tb_mealy_table_ctrl: vector tables, corner sequences and random traffic against a table-level model
module tb_mealy_table_ctrl;
    localparam int SW = 3;
    localparam int IW = 2;
    localparam int NS = 3;

    logic clk = 1'b0, reset = 1'b1, cfg_we = 1'b0, cfg_out = 1'b0;
    logic start = 1'b0, stop = 1'b0, sym_valid = 1'b0;
    logic [SW-1:0] cfg_state = '0, cfg_next = '0, init_state = '0;
    logic [IW-1:0] cfg_sym = '0, sym = '0;

    logic d_ready, d_out, d_ov, d_busy, d_fault;
    logic [SW-1:0] d_state;
    logic [15:0] d_cnt;
    logic s_ready, s_out, s_ov, s_busy, s_fault;
    logic [SW-1:0] s_state;
    logic [1:0] s_cnt;

    int checks = 0, errors = 0;

    typedef enum {M_IDLE, M_RUN, M_FAULT} mode_t;
    int    m_next [8][4];
    bit    m_tout [8][4];
    bit    m_wr   [8][4];
    mode_t m_mode = M_IDLE;
    int    m_state = 0, m_steps = 0;
    bit    m_out = 0, m_ov = 0;

    typedef struct { logic [IW-1:0] sym; logic [SW-1:0] nst; logic o; } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    mealy_table_ctrl u_dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_state(cfg_state), .cfg_sym(cfg_sym),
        .cfg_next(cfg_next), .cfg_out(cfg_out), .init_state(init_state), .start(start), .stop(stop),
        .sym_valid(sym_valid), .sym(sym), .sym_ready(d_ready), .state(d_state), .out(d_out),
        .out_valid(d_ov), .busy(d_busy), .fault(d_fault), .step_cnt(d_cnt)
    );

    mealy_table_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_state(cfg_state), .cfg_sym(cfg_sym),
        .cfg_next(cfg_next), .cfg_out(cfg_out), .init_state(init_state), .start(start), .stop(stop),
        .sym_valid(sym_valid), .sym(sym), .sym_ready(s_ready), .state(s_state), .out(s_out),
        .out_valid(s_ov), .busy(s_busy), .fault(s_fault), .step_cnt(s_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clock();
        int n;
        bit o;
        m_ov = 0;
        if (reset) begin
            foreach (m_wr[i, j]) begin
                m_wr[i][j] = 0;
                m_next[i][j] = 0;
                m_tout[i][j] = 0;
            end
            m_mode = M_IDLE;
            m_state = 0;
            m_out = 0;
            m_steps = 0;
        end else if (m_mode == M_RUN) begin
            if (stop) m_mode = M_IDLE;
            else if (sym_valid) begin
                if (m_wr[m_state][int'(sym)]) begin
                    n = m_next[m_state][int'(sym)];
                    o = m_tout[m_state][int'(sym)];
                    m_state = n;
                    m_out = o;
                    m_ov = 1;
                    m_steps++;
                end else m_mode = M_FAULT;
            end
        end else begin
            if (m_mode == M_IDLE && cfg_we && int'(cfg_state) < NS && int'(cfg_next) < NS) begin
                m_next[int'(cfg_state)][int'(cfg_sym)] = int'(cfg_next);
                m_tout[int'(cfg_state)][int'(cfg_sym)] = cfg_out;
                m_wr[int'(cfg_state)][int'(cfg_sym)] = 1;
            end
            if (start) begin
                if (int'(init_state) < NS) begin
                    m_mode = M_RUN;
                    m_state = int'(init_state);
                    m_out = 0;
                    m_steps = 0;
                end else m_mode = M_FAULT;
            end else if (stop) m_mode = M_IDLE;
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".state"}, int'(d_state), m_state);
        chk({tag, ".out"}, int'(d_out), int'(m_out));
        chk({tag, ".out_valid"}, int'(d_ov), int'(m_ov));
        chk({tag, ".busy"}, int'(d_busy), int'(m_mode == M_RUN));
        chk({tag, ".fault"}, int'(d_fault), int'(m_mode == M_FAULT));
        chk({tag, ".sym_ready"}, int'(d_ready), int'(m_mode == M_RUN && !stop));
        chk({tag, ".step_cnt"}, int'(d_cnt), m_steps > 65535 ? 65535 : m_steps);
        chk({tag, ".sat_cnt"}, int'(s_cnt), m_steps > 3 ? 3 : m_steps);
        chk({tag, ".sat_state"}, int'(s_state), m_state);
    endtask

    task automatic cycle(input string tag);
        model_clock();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic wr(input int s, input int y, input int n, input bit o);
        cfg_we = 1'b1;
        cfg_state = s[SW-1:0];
        cfg_sym = y[IW-1:0];
        cfg_next = n[SW-1:0];
        cfg_out = o;
        cycle("cfg");
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input int s);
        start = 1'b1;
        init_state = s[SW-1:0];
        cycle("start");
        start = 1'b0;
    endtask

    task automatic do_stop();
        sym_valid = 1'b0;
        stop = 1'b1;
        cycle("stop");
        stop = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2'd0, 3'd1, 1'b1};
        vecs[1] = '{2'd0, 3'd2, 1'b1};
        vecs[2] = '{2'd0, 3'd0, 1'b1};
        vecs[3] = '{2'd2, 3'd1, 1'b1};
        vecs[4] = '{2'd3, 3'd0, 1'b0};

        cycle("reset");
        cycle("reset");
        chk("reset_state", int'(d_state), 0);
        chk("reset_ready", int'(d_ready), 0);
        reset = 1'b0;

        wr(0, 0, 5, 1'b0);
        wr(3, 0, 1, 1'b1);
        wr(0, 0, 2, 1'b0);
        wr(0, 0, 1, 1'b1); wr(0, 1, 2, 1'b0); wr(0, 2, 1, 1'b1); wr(0, 3, 0, 1'b0);
        wr(1, 0, 2, 1'b1); wr(1, 1, 2, 1'b1); wr(1, 2, 2, 1'b1); wr(1, 3, 0, 1'b0);
        wr(2, 0, 0, 1'b1); wr(2, 1, 0, 1'b1); wr(2, 2, 2, 1'b0); wr(2, 3, 0, 1'b0);

        do_start(0);
        chk("start_busy", int'(d_busy), 1);
        chk("start_ready", int'(d_ready), 1);
        sym_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sym = vecs[i].sym;
            cycle("vec");
            chk($sformatf("vec%0d.state", i), int'(d_state), int'(vecs[i].nst));
            chk($sformatf("vec%0d.out", i), int'(d_out), int'(vecs[i].o));
            chk($sformatf("vec%0d.ov", i), int'(d_ov), 1);
        end
        sym_valid = 1'b0;
        cycle("idle_run");
        chk("vec_cnt", int'(d_cnt), 5);
        chk("vec_sat_cnt", int'(s_cnt), 3);
        chk("vec_ov_drop", int'(d_ov), 0);

        wr(1, 3, 2, 1'b1);
        sym_valid = 1'b1;
        sym = 2'd0;
        stop = 1'b1;
        #1;
        chk("stop_ready", int'(d_ready), 0);
        cycle("stop_mid");
        stop = 1'b0;
        sym_valid = 1'b0;
        chk("stop_busy", int'(d_busy), 0);
        chk("stop_state", int'(d_state), 0);
        chk("stop_ov", int'(d_ov), 0);
        do_start(1);
        sym_valid = 1'b1;
        sym = 2'd3;
        cycle("rerun");
        sym_valid = 1'b0;
        chk("rerun_state", int'(d_state), 0);
        chk("rerun_out", int'(d_out), 0);
        do_stop();

        do_start(5);
        chk("bad_init_fault", int'(d_fault), 1);
        chk("bad_init_busy", int'(d_busy), 0);
        chk("bad_init_state", int'(d_state), 0);
        do_start(2);
        chk("fault_restart", int'(d_busy), 1);

        sym_valid = 1'b1;
        sym = 2'd0;
        cycle("b2b");
        cycle("b2b");
        reset = 1'b1;
        cycle("mid_reset");
        reset = 1'b0;
        sym_valid = 1'b0;
        chk("rst_state", int'(d_state), 0);
        chk("rst_busy", int'(d_busy), 0);
        chk("rst_ov", int'(d_ov), 0);
        chk("rst_cnt", int'(d_cnt), 0);
        do_start(0);
        sym_valid = 1'b1;
        cycle("cleared_entry");
        sym_valid = 1'b0;
        chk("cleared_fault", int'(d_fault), 1);
        do_stop();

        wr(0, 0, 1, 1'b1);
        do_start(0);
        sym_valid = 1'b1;
        sym = 2'd1;
        cycle("unwritten");
        sym_valid = 1'b0;
        chk("unw_fault", int'(d_fault), 1);
        chk("unw_ov", int'(d_ov), 0);
        chk("unw_cnt", int'(d_cnt), 0);
        chk("unw_state", int'(d_state), 0);
        do_stop();

        for (int i = 0; i < 3000; i++) begin
            reset = $urandom_range(0, 299) == 0;
            cfg_we = $urandom_range(0, 1) == 1;
            cfg_state = SW'($urandom_range(0, 3));
            cfg_sym = IW'($urandom_range(0, 3));
            cfg_next = SW'($urandom_range(0, 3));
            cfg_out = $urandom_range(0, 1) == 1;
            init_state = SW'($urandom_range(0, 4));
            start = $urandom_range(0, 7) == 0;
            stop = $urandom_range(0, 11) == 0;
            sym_valid = $urandom_range(0, 3) != 0;
            sym = IW'($urandom_range(0, 3));
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mealy_table_ctrl.md
Name: mealy_table_ctrl

Overview:
Table-driven controller for the team's configurable Mealy machines. The transition table (next state and output per state/input pair) is written through a config port while the block is idle. Once started, the block steps the machine one input symbol per valid/ready handshake and reports the registered state and output. It replaces per-machine hard-coded case logic, so one block runs any machine of up to 2^STATE_W states.

Parameters:
STATE_W, 3, state encoding width; table depth is 2^STATE_W states.
IN_W, 2, input symbol width; 2^IN_W symbols per state.
NUM_STATES, 3, number of legal states; any state >= NUM_STATES is illegal.
CNT_W, 16, step counter width.

Ports:
clk  input  1  clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
cfg_we  input  1  table write strobe; honoured only in IDLE.
cfg_state  input  STATE_W  table row (source state) to write.
cfg_sym  input  IN_W  table column (input symbol) to write.
cfg_next  input  STATE_W  next-state value for the entry.
cfg_out  input  1  output value for the entry.
init_state  input  STATE_W  start state, sampled on start.
start  input  1  IDLE/FAULT -> RUN request, 1-cycle pulse.
stop  input  1  RUN -> IDLE request.
sym_valid  input  1  input symbol valid.
sym  input  IN_W  input symbol.
sym_ready  output  1  block accepts a symbol this cycle.
state  output  STATE_W  current machine state (registered).
out  output  1  Mealy output of the last accepted step (registered).
out_valid  output  1  1-cycle pulse: state/out updated by a step.
busy  output  1  controller in RUN.
fault  output  1  controller in FAULT.
step_cnt  output  CNT_W  accepted steps since last start, saturating.

Behaviour:
- Reset (synchronous, active-high): ctrl FSM=IDLE; state=0, out=0, out_valid=0, sym_ready=0, busy=0, fault=0, step_cnt=0.
- Reset also clears every table entry: next=0, out=0, written-flag=0. Reset mid-RUN aborts immediately; no out_valid.
- Control FSM has three states: IDLE, RUN, FAULT.
- IDLE:
  - cfg_we=1 writes {cfg_next, cfg_out} to entry [cfg_state][cfg_sym] and sets its written-flag. Last write wins.
  - A write with cfg_next >= NUM_STATES or cfg_state >= NUM_STATES is dropped; table unchanged.
  - start=1: if init_state < NUM_STATES, then state<=init_state, out<=0, step_cnt<=0, and go to RUN. Otherwise go to FAULT; state is unchanged.
  - start and cfg_we in the same cycle: the write lands first, then the FSM goes to RUN.
- RUN:
  - busy=1. sym_ready=1 unless stop=1 in the same cycle; it is combinational from the FSM state and stop.
  - cfg_we is ignored.
  - Step happens on sym_valid & sym_ready. The entry E=[state][sym] is read combinationally. On the next edge: state<=E.next, out<=E.out, out_valid=1 for exactly that cycle, step_cnt+=1 (saturates at all-ones).
  - One step per cycle is permitted; back-to-back accepts give consecutive out_valid pulses.
  - If E's written-flag=0: no state/out update, no out_valid, step_cnt unchanged; go to FAULT.
  - stop=1: go to IDLE; no step that cycle. state and out hold their values.
- FAULT:
  - fault=1, sym_ready=0; table and cfg_we behave as in IDLE-blocked (writes ignored).
  - start with a legal init_state goes to RUN, as from IDLE.
  - stop goes to IDLE, clearing fault.
- Latency: accept edge -> state/out/out_valid visible 1 cycle later. start -> sym_ready=1 1 cycle later.
- start in RUN is ignored. start and stop together in IDLE/FAULT: start wins.

Test Plan:
- Load the 3-state table (s0: sym0->1/1, sym1->2/0, sym2->1/1, sym3->0/0; s1: sym0-2->2/1, sym3->0/0; s2: sym0,1->0/1, sym2->2/0, sym3->0/0). start with init_state=0; feed sym 0,0,0,2,3 back-to-back -> states 1,2,0,1,0; outs 1,1,1,1,0; five consecutive out_valid pulses; step_cnt=5.
- start with init_state=5 (NUM_STATES=3) -> fault=1 next cycle, busy=0, state unchanged.
- Write only entry [0][0]; start at 0; feed sym=1 -> fault=1, no out_valid, step_cnt=0, state=0.
- Mid-run stop with sym_valid=1 in the same cycle -> no step, sym_ready=0; IDLE next cycle, state held. A cfg_we issued in RUN does not alter the table (verify by re-running).
- Assert reset during a back-to-back RUN stream -> next cycle all outputs zero, FSM in IDLE. A previously written entry now reports unwritten (start, step -> FAULT).
- CNT_W=2: perform 5 steps -> step_cnt saturates at 3.
